aes128_rsm_ctrl: RTL and testbench

Sequencer that drives one `AES128_RSM_Core` instance and gives the host a simple key / plaintext / ciphertext handshake. It holds the host key and re-issues it before every encryption, because the core's round-key register evolves during a run. It draws a fresh rotation offset for the mask from an LFSR on each encryption. It also captures the result into an output register and flags a core that never completes.

---
 rtl/aes128_rsm_ctrl.sv | 157 +++++++++++++++
 tb/tb_aes128_rsm_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_rsm_ctrl.sv
// Host-side sequencer for one AES128_RSM_Core: re-issues the stored key, starts the core with a
// fresh LFSR-derived mask rotation, captures the result and flags a core that never answers.
module aes128_rsm_ctrl #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] i_key,
  input  logic         i_key_valid,
  input  logic [15:0]  i_seed,
  input  logic         i_seed_valid,
  input  logic         i_mask_en,
  input  logic [127:0] i_plaintext,
  input  logic         i_plaintext_valid,
  output logic         o_plaintext_ready,
  output logic [127:0] o_ciphertext,
  output logic         o_ciphertext_valid,
  input  logic         i_ciphertext_ready,
  output logic         o_busy,
  output logic         o_error,
  output logic [127:0] o_core_key,
  output logic         o_core_key_valid,
  output logic [127:0] o_core_plaintext,
  output logic         o_core_plaintext_valid,
  output logic [3:0]   o_core_rotate,
  input  logic [127:0] i_core_ciphertext,
  input  logic         i_core_ciphertext_valid,
  input  logic         i_core_busy,
  output logic [1:0]   o_dbg_state
);

  // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
  // valid, once raised, is held with stable data until that edge.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_LOAD = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam int unsigned CW = $clog2(TIMEOUT + 1) + 1;

  state_t         state_q;
  logic [127:0]   key_q;
  logic           key_loaded_q;
  logic [127:0]   core_key_q;
  logic           core_key_valid_q;
  logic [127:0]   core_pt_q;
  logic           core_pt_valid_q;
  logic [3:0]     rot_q;
  logic [15:0]    lfsr_q;
  logic [15:0]    lfsr_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [127:0]   ct_q;
  logic           ct_valid_q;
  logic           error_q;
  logic           ready;
  logic           accept;

  always_comb begin
    ready  = (state_q == ST_IDLE) & key_loaded_q & ~error_q & ~ct_valid_q & ~i_core_busy;
    accept = ready & i_plaintext_valid;
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    cnt_d  = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      key_q            <= '0;
      key_loaded_q     <= 1'b0;
      core_key_q       <= '0;
      core_key_valid_q <= 1'b0;
      core_pt_q        <= '0;
      core_pt_valid_q  <= 1'b0;
      rot_q            <= '0;
      lfsr_q           <= LFSR_INIT;
      cnt_q            <= '0;
      ct_q             <= '0;
      ct_valid_q       <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      core_key_valid_q <= 1'b0;
      core_pt_valid_q  <= 1'b0;

      if (i_key_valid) begin
        key_q        <= i_key;
        key_loaded_q <= 1'b1;
      end

      if (i_seed_valid) begin
        lfsr_q <= (i_seed == 16'h0000) ? LFSR_INIT : i_seed;
      end else if (state_q == ST_LOAD) begin
        lfsr_q <= lfsr_d;
      end

      if (ct_valid_q && i_ciphertext_ready) begin
        ct_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            core_pt_q        <= i_plaintext;
            // A key arriving together with the plaintext belongs to this run.
            core_key_q       <= i_key_valid ? i_key : key_q;
            core_key_valid_q <= 1'b1;
            state_q          <= ST_KEY;
          end
        end
        ST_KEY: begin
          core_pt_valid_q <= 1'b1;
          // Rotation is registered so it is stable from the LOAD strobe until the next LOAD.
          rot_q           <= i_mask_en ? lfsr_q[3:0] : 4'h0;
          state_q         <= ST_LOAD;
        end
        ST_LOAD: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_core_ciphertext_valid) begin
            ct_q       <= i_core_ciphertext;
            ct_valid_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (cnt_d == CW'(TIMEOUT)) begin
            error_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (i_key_valid) begin
        error_q <= 1'b0;
      end
    end
  end

  assign o_plaintext_ready      = ready;
  assign o_ciphertext           = ct_q;
  assign o_ciphertext_valid     = ct_valid_q;
  assign o_busy                 = (state_q != ST_IDLE);
  assign o_error                = error_q;
  assign o_core_key             = core_key_q;
  assign o_core_key_valid       = core_key_valid_q;
  assign o_core_plaintext       = core_pt_q;
  assign o_core_plaintext_valid = core_pt_valid_q;
  assign o_core_rotate          = rot_q;
  assign o_dbg_state            = state_q;

endmodule

// File: tb/tb_aes128_rsm_ctrl.sv
// Directed bench for aes128_rsm_ctrl with a behavioural 11-cycle core stub.
module tb_aes128_rsm_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] INV_KEY  = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
  localparam logic [127:0] KEY2     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] ONES     = 128'hffffffffffffffffffffffffffffffff;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] i_key;
  logic         i_key_valid;
  logic [15:0]  i_seed;
  logic         i_seed_valid;
  logic         i_mask_en;
  logic [127:0] i_plaintext;
  logic         i_plaintext_valid;
  logic         o_plaintext_ready;
  logic [127:0] o_ciphertext;
  logic         o_ciphertext_valid;
  logic         i_ciphertext_ready;
  logic         o_busy;
  logic         o_error;
  logic [127:0] o_core_key;
  logic         o_core_key_valid;
  logic [127:0] o_core_plaintext;
  logic         o_core_plaintext_valid;
  logic [3:0]   o_core_rotate;
  logic [127:0] core_ct;
  logic         core_ct_valid;
  logic         core_busy;
  logic [1:0]   o_dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_rsm_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .i_key(i_key), .i_key_valid(i_key_valid),
    .i_seed(i_seed), .i_seed_valid(i_seed_valid), .i_mask_en(i_mask_en),
    .i_plaintext(i_plaintext), .i_plaintext_valid(i_plaintext_valid),
    .o_plaintext_ready(o_plaintext_ready),
    .o_ciphertext(o_ciphertext), .o_ciphertext_valid(o_ciphertext_valid),
    .i_ciphertext_ready(i_ciphertext_ready),
    .o_busy(o_busy), .o_error(o_error),
    .o_core_key(o_core_key), .o_core_key_valid(o_core_key_valid),
    .o_core_plaintext(o_core_plaintext), .o_core_plaintext_valid(o_core_plaintext_valid),
    .o_core_rotate(o_core_rotate),
    .i_core_ciphertext(core_ct), .i_core_ciphertext_valid(core_ct_valid),
    .i_core_busy(core_busy), .o_dbg_state(o_dbg_state)
  );

  // ---------------- core stub: result strobe 11 cycles after the start strobe ----------------
  logic         stub_run;
  logic [3:0]   stub_cnt;
  logic [3:0]   stub_lat = 4'd9;
  logic         stub_dead = 1'b0;
  logic [127:0] stub_key;
  logic [127:0] stub_pt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_run <= 1'b0; stub_cnt <= '0; stub_key <= '0; stub_pt <= '0;
      core_ct_valid <= 1'b0; core_ct <= '0;
    end else begin
      core_ct_valid <= 1'b0;
      if (o_core_key_valid) stub_key <= o_core_key;
      if (o_core_plaintext_valid) begin
        stub_pt <= o_core_plaintext; stub_cnt <= '0; stub_run <= ~stub_dead;
      end else if (stub_run) begin
        if (stub_cnt == stub_lat) begin
          core_ct_valid <= 1'b1;
          core_ct <= (stub_key == FIPS_KEY && stub_pt == FIPS_PT) ? FIPS_CT : (stub_key ^ stub_pt);
          stub_run <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt + 4'd1;
        end
      end
    end
  end
  assign core_busy = stub_run;

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [127:0] k);
    i_key = k; i_key_valid = 1'b1;
    @(negedge clk);
    i_key_valid = 1'b0;
  endtask

  task automatic load_seed(input logic [15:0] s);
    i_seed = s; i_seed_valid = 1'b1;
    @(negedge clk);
    i_seed_valid = 1'b0;
  endtask

  // Returns at the negedge of cycle A+1 (A = accept cycle).
  task automatic send_pt(input logic [127:0] pt);
    int n;
    n = 0;
    i_plaintext = pt; i_plaintext_valid = 1'b1;
    while (o_plaintext_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin n_vec++; n_err++; $display("FAIL send_pt_wait: ready low for %0d cycles, required < 40", n); end
    @(negedge clk);
    i_plaintext_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    n_vec++; if ({o_plaintext_ready, o_busy, o_error, o_ciphertext_valid} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {o_plaintext_ready, o_busy, o_error, o_ciphertext_valid}); end
    n_vec++; if ({o_core_key_valid, o_core_plaintext_valid, o_core_rotate, o_dbg_state} !== 8'h00) begin n_err++; $display("FAIL reset_core_ctl: got %h want 00", {o_core_key_valid, o_core_plaintext_valid, o_core_rotate, o_dbg_state}); end
    n_vec++; if ({o_core_key, o_core_plaintext, o_ciphertext} !== 384'h0) begin n_err++; $display("FAIL reset_data: got nonzero %h want 0", {o_core_key, o_core_plaintext, o_ciphertext}); end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (o_plaintext_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_nokey: got %b want 0", o_plaintext_ready); end
  endtask

  task automatic test_no_key;
    int bad;
    bad = 0;
    i_plaintext = FIPS_PT; i_plaintext_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if ({o_plaintext_ready, o_core_key_valid, o_core_plaintext_valid, o_busy} !== 4'b0000) bad++;
      @(negedge clk);
    end
    i_plaintext_valid = 1'b0;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL no_key_idle: %0d cycles with ready/strobe/busy high, want 0", bad); end
  endtask

  task automatic test_fips;
    int bad;
    load_key(FIPS_KEY);
    n_vec++; if (o_plaintext_ready !== 1'b1) begin n_err++; $display("FAIL fips_ready: got %b want 1", o_plaintext_ready); end
    send_pt(FIPS_PT);
    n_vec++; if ({o_core_key_valid, o_core_plaintext_valid, o_busy} !== 3'b101) begin n_err++; $display("FAIL fips_key_strobe_a1: got %b want 101", {o_core_key_valid, o_core_plaintext_valid, o_busy}); end
    n_vec++; if (o_core_key !== FIPS_KEY) begin n_err++; $display("FAIL fips_core_key: got %h want %h", o_core_key, FIPS_KEY); end
    @(negedge clk);
    n_vec++; if ({o_core_key_valid, o_core_plaintext_valid} !== 2'b01) begin n_err++; $display("FAIL fips_load_strobe_a2: got %b want 01", {o_core_key_valid, o_core_plaintext_valid}); end
    n_vec++; if (o_core_plaintext !== FIPS_PT) begin n_err++; $display("FAIL fips_core_pt: got %h want %h", o_core_plaintext, FIPS_PT); end
    n_vec++; if (o_core_rotate !== 4'h1) begin n_err++; $display("FAIL fips_rotate: got %h want 1", o_core_rotate); end
    bad = 0;
    for (int k = 3; k <= 13; k++) begin
      @(negedge clk);
      if (o_ciphertext_valid !== 1'b0 || o_busy !== 1'b1) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL fips_wait_window: %0d bad cycles in A+3..A+13, want 0", bad); end
    @(negedge clk);
    n_vec++; if ({o_ciphertext_valid, o_busy} !== 2'b10) begin n_err++; $display("FAIL fips_valid_a14: got %b want 10", {o_ciphertext_valid, o_busy}); end
    n_vec++; if (o_ciphertext !== FIPS_CT) begin n_err++; $display("FAIL fips_ct: got %h want %h", o_ciphertext, FIPS_CT); end
    @(negedge clk);
    n_vec++; if ({o_ciphertext_valid, o_plaintext_ready} !== 2'b01) begin n_err++; $display("FAIL fips_a15: got %b want 01", {o_ciphertext_valid, o_plaintext_ready}); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_rot [3];
    int prev;
    exp_rot[0] = 4'h1; exp_rot[1] = 4'h0; exp_rot[2] = 4'h0;
    for (int m = 1; m >= 0; m--) begin
      i_mask_en = m[0];
      load_seed(16'h0001);
      prev = -1;
      for (int i = 0; i < 3; i++) begin
        send_pt(FIPS_PT);
        if (prev >= 0) begin
          n_vec++; if (cyc - prev != 15) begin n_err++; $display("FAIL b2b_spacing m%0d blk%0d: got %0d cycles want 15", m, i, cyc - prev); end
        end
        prev = cyc;
        @(negedge clk);
        n_vec++; if (o_core_rotate !== (m[0] ? exp_rot[i] : 4'h0)) begin n_err++; $display("FAIL b2b_rotate m%0d blk%0d: got %h want %h", m, i, o_core_rotate, m[0] ? exp_rot[i] : 4'h0); end
        repeat (12) @(negedge clk);
        n_vec++; if (o_ciphertext_valid !== 1'b1 || o_ciphertext !== FIPS_CT) begin n_err++; $display("FAIL b2b_ct m%0d blk%0d: got v=%b %h want v=1 %h", m, i, o_ciphertext_valid, o_ciphertext, FIPS_CT); end
        @(negedge clk);
      end
    end
    // A zero seed must fall back to the init value, whose low nibble is 1.
    i_mask_en = 1'b1;
    load_seed(16'h0000);
    send_pt(FIPS_PT);
    @(negedge clk);
    n_vec++; if (o_core_rotate !== 4'h1) begin n_err++; $display("FAIL seed_zero_rotate: got %h want 1", o_core_rotate); end
    repeat (13) @(negedge clk);
  endtask

  task automatic test_key_timing;
    send_pt(128'h0);
    i_key = KEY2; i_key_valid = 1'b1;
    @(negedge clk);
    i_key_valid = 1'b0;
    n_vec++; if (o_core_key !== FIPS_KEY) begin n_err++; $display("FAIL key_midrun_core_key: got %h want %h", o_core_key, FIPS_KEY); end
    repeat (12) @(negedge clk);
    n_vec++; if (o_ciphertext !== FIPS_KEY) begin n_err++; $display("FAIL key_midrun_ct: got %h want %h", o_ciphertext, FIPS_KEY); end
    @(negedge clk);
    send_pt(128'h0);
    repeat (13) @(negedge clk);
    n_vec++; if (o_ciphertext !== KEY2) begin n_err++; $display("FAIL key_next_run_ct: got %h want %h", o_ciphertext, KEY2); end
    @(negedge clk);
    // key and plaintext presented on the same accept cycle
    i_plaintext = 128'h0; i_plaintext_valid = 1'b1; i_key = FIPS_KEY; i_key_valid = 1'b1;
    n_vec++; if (o_plaintext_ready !== 1'b1) begin n_err++; $display("FAIL key_accept_ready: got %b want 1", o_plaintext_ready); end
    @(negedge clk);
    i_plaintext_valid = 1'b0; i_key_valid = 1'b0;
    n_vec++; if (o_core_key_valid !== 1'b1 || o_core_key !== FIPS_KEY) begin n_err++; $display("FAIL key_accept_core_key: got v=%b %h want v=1 %h", o_core_key_valid, o_core_key, FIPS_KEY); end
    repeat (13) @(negedge clk);
    n_vec++; if (o_ciphertext !== FIPS_KEY) begin n_err++; $display("FAIL key_accept_ct: got %h want %h", o_ciphertext, FIPS_KEY); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int bad;
    i_ciphertext_ready = 1'b0;
    send_pt(ONES);
    repeat (13) @(negedge clk);
    n_vec++; if (o_ciphertext_valid !== 1'b1 || o_ciphertext !== INV_KEY) begin n_err++; $display("FAIL bp_first_ct: got v=%b %h want v=1 %h", o_ciphertext_valid, o_ciphertext, INV_KEY); end
    i_plaintext = FIPS_PT; i_plaintext_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_ciphertext_valid !== 1'b1 || o_ciphertext !== INV_KEY || o_plaintext_ready !== 1'b0 || o_core_key_valid !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
    i_ciphertext_ready = 1'b1;
    @(negedge clk);
    n_vec++; if ({o_ciphertext_valid, o_plaintext_ready} !== 2'b01 || o_ciphertext !== INV_KEY) begin n_err++; $display("FAIL bp_drain: got v=%b r=%b %h want v=0 r=1 %h", o_ciphertext_valid, o_plaintext_ready, o_ciphertext, INV_KEY); end
    @(negedge clk);
    i_plaintext_valid = 1'b0;
    n_vec++; if (o_core_key_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_accept: got %b want 1", o_core_key_valid); end
    repeat (13) @(negedge clk);
    n_vec++; if (o_ciphertext_valid !== 1'b1 || o_ciphertext !== FIPS_CT) begin n_err++; $display("FAIL bp_second_ct: got v=%b %h want v=1 %h", o_ciphertext_valid, o_ciphertext, FIPS_CT); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int early;
    stub_dead = 1'b1;
    send_pt(FIPS_PT);
    early = 0;
    for (int k = 1; k <= 17; k++) begin
      if (o_error !== 1'b0) early++;
      @(negedge clk);
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL to_early: error high %0d cycles before A+18, want 0", early); end
    n_vec++; if ({o_error, o_busy, o_dbg_state, o_plaintext_ready, o_ciphertext_valid} !== 6'b100000) begin n_err++; $display("FAIL to_a18: got %b want 100000", {o_error, o_busy, o_dbg_state, o_plaintext_ready, o_ciphertext_valid}); end
    i_plaintext = FIPS_PT; i_plaintext_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if ({o_error, o_plaintext_ready, o_core_key_valid} !== 3'b100) begin n_err++; $display("FAIL to_blocked: got %b want 100", {o_error, o_plaintext_ready, o_core_key_valid}); end
    i_plaintext_valid = 1'b0;
    stub_dead = 1'b0;
    load_key(FIPS_KEY);
    n_vec++; if ({o_error, o_plaintext_ready} !== 2'b01) begin n_err++; $display("FAIL to_cleared: got %b want 01", {o_error, o_plaintext_ready}); end
    // core answer on the very cycle the timeout fires
    stub_lat = 4'd13;
    send_pt(FIPS_PT);
    repeat (17) @(negedge clk);
    n_vec++; if ({o_ciphertext_valid, o_error} !== 2'b10 || o_ciphertext !== FIPS_CT) begin n_err++; $display("FAIL to_race: got v=%b e=%b %h want v=1 e=0 %h", o_ciphertext_valid, o_error, o_ciphertext, FIPS_CT); end
    stub_lat = 4'd9;
    @(negedge clk);
  endtask

  task automatic test_reset_wait;
    int bad;
    send_pt(FIPS_PT);
    repeat (5) @(negedge clk);
    n_vec++; if (o_dbg_state !== 2'd3) begin n_err++; $display("FAIL rst_pre_state: got %0d want 3", o_dbg_state); end
    reset_n = 1'b0;
    #1;
    n_vec++; if ({o_busy, o_dbg_state, o_core_rotate, o_plaintext_ready, o_ciphertext_valid, o_error} !== 10'b0) begin n_err++; $display("FAIL rst_flags: got %b want 0", {o_busy, o_dbg_state, o_core_rotate, o_plaintext_ready, o_ciphertext_valid, o_error}); end
    n_vec++; if ({o_core_key, o_core_plaintext} !== 256'h0) begin n_err++; $display("FAIL rst_core_data: got %h want 0", {o_core_key, o_core_plaintext}); end
    @(negedge clk);
    reset_n = 1'b1;
    i_plaintext_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if ({o_plaintext_ready, o_core_key_valid, o_ciphertext_valid, o_busy} !== 4'b0000) bad++;
    end
    i_plaintext_valid = 1'b0;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rst_needs_key: %0d bad cycles, want 0", bad); end
    load_key(FIPS_KEY);
    n_vec++; if (o_plaintext_ready !== 1'b1) begin n_err++; $display("FAIL rst_reload_ready: got %b want 1", o_plaintext_ready); end
    send_pt(FIPS_PT);
    repeat (13) @(negedge clk);
    n_vec++; if (o_ciphertext_valid !== 1'b1 || o_ciphertext !== FIPS_CT) begin n_err++; $display("FAIL rst_rerun_ct: got v=%b %h want v=1 %h", o_ciphertext_valid, o_ciphertext, FIPS_CT); end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    i_key = '0; i_key_valid = 1'b0; i_seed = '0; i_seed_valid = 1'b0; i_mask_en = 1'b1;
    i_plaintext = '0; i_plaintext_valid = 1'b0; i_ciphertext_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    test_no_key;
    test_fips;
    test_back_to_back;
    test_key_timing;
    test_backpressure;
    test_timeout;
    test_reset_wait;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
